// File: rtl/sort_seq_ctrl.sv
// Batch sequencer for sort_stage: loads M words into a chi matrix, then emits them
// max-first by feeding the stage its own reduced matrix one pass per output word.
package sort_pkg;
    localparam int M = 4;
    localparam int N = 8;
endpackage

module sort_seq_ctrl
    import sort_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N-1:0]          i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [M-1:0][N-1:0]   o_stage_chi,
    input  logic [M-1:0][N-1:0]   i_stage_chi,
    input  logic [N-1:0]          i_stage_y_q,
    output logic [N-1:0]          o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_last,
    output logic                  o_busy
);

    localparam int CW = $clog2(M + 1);
    localparam logic [CW-1:0] M_CNT    = CW'(M);
    localparam logic [CW-1:0] LAST_CNT = CW'(M - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SORT} state_t;

    state_t               state;
    logic [M-1:0][N-1:0]  chi;
    logic [CW-1:0]        ld_cnt;
    logic [CW-1:0]        em_cnt;
    logic                 accept;
    logic                 adv;
    logic                 out_xfer;

    assign o_ready     = (state == IDLE) || (state == LOAD);
    assign o_busy      = (state != IDLE);
    assign o_stage_chi = chi;

    assign accept   = i_valid & o_ready;
    assign out_xfer = o_valid & i_ready;
    // A new pass is taken only when the output register is empty or draining this edge.
    assign adv      = (state == SORT) && (em_cnt < M_CNT) && (!o_valid || i_ready);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            chi     <= '0;
            ld_cnt  <= '0;
            em_cnt  <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (accept) begin
                        for (int r = 0; r < M; r++) begin
                            if (ld_cnt == CW'(r)) begin
                                chi[r] <= i_data;
                            end
                        end
                        if (ld_cnt == LAST_CNT) begin
                            state  <= SORT;
                            ld_cnt <= '0;
                            em_cnt <= '0;
                        end else begin
                            state  <= LOAD;
                            ld_cnt <= ld_cnt + CW'(1);
                        end
                    end
                end
                SORT: begin
                    if (adv) begin
                        o_data  <= i_stage_y_q;
                        o_valid <= 1'b1;
                        o_last  <= (em_cnt == LAST_CNT);
                        chi     <= i_stage_chi;
                        em_cnt  <= em_cnt + CW'(1);
                    end else if (out_xfer) begin
                        o_valid <= 1'b0;
                        o_last  <= 1'b0;
                    end
                    // chi is left stale on exit; the next load rewrites every row.
                    if (out_xfer && o_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Bench for sort_seq_ctrl with a behavioural max-extract stage attached and a
// queue-sort reference for randomized batches.
module tb_sort_seq_ctrl;
    import sort_pkg::*;

    typedef logic [N-1:0] vec_t [M];
    typedef struct {
        vec_t din;
        vec_t dout;
        int   rmode;
        int   gaps;
    } vec_rec_t;

    logic                 clk;
    logic                 rst_n;
    logic [N-1:0]         i_data;
    logic                 i_valid;
    logic                 o_ready;
    logic [M-1:0][N-1:0]  stage_in;
    logic [M-1:0][N-1:0]  stage_out;
    logic [N-1:0]         stage_y;
    logic [N-1:0]         o_data;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_last;
    logic                 o_busy;

    int checks = 0;
    int errors = 0;

    sort_seq_ctrl dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_stage_chi (stage_in),
        .i_stage_chi (stage_out),
        .i_stage_y_q (stage_y),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_last      (o_last),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in sort_stage: report the largest row and zero it out of the matrix.
    logic [1:0] max_idx;
    always_comb begin
        max_idx = 2'd0;
        for (int r = 1; r < M; r++) begin
            if (stage_in[r] > stage_in[max_idx]) max_idx = 2'(r);
        end
        stage_y            = stage_in[max_idx];
        stage_out          = stage_in;
        stage_out[max_idx] = '0;
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input vec_t v, input int gap_mask);
        int guard;
        for (int i = 0; i < M; i++) begin
            if (gap_mask[i]) begin
                i_valid = 1'b0;
                step();
            end
            i_valid = 1'b1;
            i_data  = v[i];
            guard   = 0;
            while (!o_ready && guard < 100) begin
                step();
                guard++;
            end
            if (guard >= 100) check("load_timeout", 1, 0);
            step();
        end
        i_valid = 1'b0;
    endtask

    task automatic drain(input vec_t exp, input int rmode);
        int got = 0;
        int cyc = 0;
        int first = -1;
        int lastc = -1;
        logic [N-1:0] prev = '0;
        bit stalled = 1'b0;
        while (got < M && cyc < 200) begin
            case (rmode)
                0:       i_ready = 1'b1;
                1:       i_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: i_ready = 1'($urandom_range(0, 1));
            endcase
            check("ready_low_in_sort", int'(o_ready), 0);
            if (stalled) begin
                check("hold_data", int'(o_data), int'(prev));
                check("hold_valid", int'(o_valid), 1);
            end
            if (o_valid && i_ready) begin
                if (first < 0) first = cyc;
                lastc = cyc;
                check("out_data", int'(o_data), int'(exp[got]));
                check("out_last", int'(o_last), (got == M - 1) ? 1 : 0);
                got++;
            end
            stalled = o_valid && !i_ready;
            prev    = o_data;
            step();
            cyc++;
        end
        check("out_count", got, M);
        if (rmode == 0) begin
            check("first_latency", first, 1);
            check("back_to_back", lastc - first, M - 1);
        end
        check("idle_busy", int'(o_busy), 0);
        check("idle_ready", int'(o_ready), 1);
        check("idle_valid", int'(o_valid), 0);
        i_ready = 1'b1;
    endtask

    vec_rec_t tbl [4];
    vec_t     rv;
    vec_t     rexp;
    int       q [$];

    initial begin
        tbl[0].din = '{8'd3, 8'd9, 8'd1, 8'd7};
        tbl[0].dout = '{8'd9, 8'd7, 8'd3, 8'd1};
        tbl[0].rmode = 0; tbl[0].gaps = 0;
        tbl[1].din = '{8'd3, 8'd9, 8'd1, 8'd7};
        tbl[1].dout = '{8'd9, 8'd7, 8'd3, 8'd1};
        tbl[1].rmode = 1; tbl[1].gaps = 0;
        tbl[2].din = '{8'hFF, 8'h00, 8'h80, 8'h80};
        tbl[2].dout = '{8'hFF, 8'h80, 8'h80, 8'h00};
        tbl[2].rmode = 0; tbl[2].gaps = 4'b0110;
        tbl[3].din = '{8'd0, 8'd0, 8'd0, 8'd0};
        tbl[3].dout = '{8'd0, 8'd0, 8'd0, 8'd0};
        tbl[3].rmode = 0; tbl[3].gaps = 0;

        rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step();
        check("rst_valid", int'(o_valid), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_ready", int'(o_ready), 1);
        check("rst_last", int'(o_last), 0);
        check("rst_data", int'(o_data), 0);
        check("rst_chi", (stage_in == '0) ? 1 : 0, 1);

        for (int t = 0; t < 4; t++) begin
            load(tbl[t].din, tbl[t].gaps);
            drain(tbl[t].dout, tbl[t].rmode);
        end
        // zero batch immediately repeated, no idle gap
        load(tbl[3].din, 0);
        drain(tbl[3].dout, 0);

        // reset in the middle of emission
        load(tbl[0].din, 0);
        i_ready = 1'b1;
        step(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", int'(o_valid), 0);
        check("async_rst_busy", int'(o_busy), 0);
        check("async_rst_data", int'(o_data), 0);
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_valid", int'(o_valid), 0);
        load(tbl[2].din, 0);
        drain(tbl[2].dout, 0);

        // i_valid kept high through SORT; the held word starts the next batch
        load(tbl[0].din, 0);
        i_valid = 1'b1;
        i_data  = 8'h55;
        drain(tbl[0].dout, 1);
        rv = '{8'h55, 8'h10, 8'hA0, 8'h20};
        rexp = '{8'hA0, 8'h55, 8'h20, 8'h10};
        load(rv, 0);
        drain(rexp, 0);

        for (int b = 0; b < 20; b++) begin
            q = {};
            for (int i = 0; i < M; i++) begin
                rv[i] = (b % 3 == 0) ? N'($urandom_range(0, 3)) : N'($urandom);
                q.push_back(int'(rv[i]));
            end
            q.rsort();
            for (int i = 0; i < M; i++) rexp[i] = N'(q[i]);
            load(rv, int'($urandom_range(0, 15)));
            drain(rexp, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
